// File: rtl/branch_cond_unit_pkg.sv
// Shared types for the branch condition unit: condition codes, flag bundle, FSM states.
// Relative branching is enabled by defining BRANCH_RELATIVE_EN.
package branch_pkg;

  localparam int AW_DEF = 16;

  localparam logic [3:0] COND_AL  = 4'h0;
  localparam logic [3:0] COND_Z   = 4'h1;
  localparam logic [3:0] COND_NZ  = 4'h2;
  localparam logic [3:0] COND_C   = 4'h3;
  localparam logic [3:0] COND_NC  = 4'h4;
  localparam logic [3:0] COND_N   = 4'h5;
  localparam logic [3:0] COND_NN  = 4'h6;
  localparam logic [3:0] COND_O   = 4'h7;
  localparam logic [3:0] COND_NO  = 4'h8;
  localparam logic [3:0] COND_D0  = 4'h9;
  localparam logic [3:0] COND_ND0 = 4'hA;
  localparam logic [3:0] COND_LT  = 4'hB;
  localparam logic [3:0] COND_GE  = 4'hC;
  localparam logic [3:0] COND_LE  = 4'hD;
  localparam logic [3:0] COND_GT  = 4'hE;
  localparam logic [3:0] COND_NV  = 4'hF;

  typedef struct packed {
    logic cf;
    logic of;
    logic nf;
    logic zf;
    logic d0;
  } flags_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EVAL     = 3'd1,
    FETCH_LO = 3'd2,
    FETCH_HI = 3'd3,
    LOAD     = 3'd4,
    SKIP     = 3'd5
  } state_t;

endpackage

// File: rtl/branch_cond_unit_if.sv
// Decoder / flag / memory / PC-update bundle; signal direction names are from the unit's view.
interface branch_cond_unit_if #(parameter int AW = 16);
  import branch_pkg::*;

  logic          i_start;
  logic [3:0]    i_cond;
  logic          i_rel;
  flags_t        i_flags;
  logic [AW-1:0] i_pc;
  logic          o_mem_req;
  logic [AW-1:0] o_mem_addr;
  logic [7:0]    i_mem_rdata;
  logic          i_mem_ack;
  logic          o_pc_load;
  logic [AW-1:0] o_pc_next;
  logic          o_taken;
  logic          o_busy;
  logic          o_done;

  modport master (
    output i_start, i_cond, i_rel, i_flags, i_pc, i_mem_rdata, i_mem_ack,
    input  o_mem_req, o_mem_addr, o_pc_load, o_pc_next, o_taken, o_busy, o_done
  );

  modport slave (
    input  i_start, i_cond, i_rel, i_flags, i_pc, i_mem_rdata, i_mem_ack,
    output o_mem_req, o_mem_addr, o_pc_load, o_pc_next, o_taken, o_busy, o_done
  );
endinterface

// File: rtl/branch_cond_unit_cond_eval.sv
// Pure combinational condition-code evaluator: 4-bit code plus flags -> branch taken.
module cond_eval
  import branch_pkg::*;
(
  input  logic [3:0] i_cond,
  input  flags_t     i_flags,
  output logic       o_taken
);

  logic w_lt;
  assign w_lt = i_flags.nf ^ i_flags.of;

  always_comb begin
    // NOTE: default first so every path assigns o_taken and no latch is inferred.
    o_taken = 1'b0;
    case (i_cond)
      COND_AL:  o_taken = 1'b1;
      COND_Z:   o_taken = i_flags.zf;
      COND_NZ:  o_taken = !i_flags.zf;
      COND_C:   o_taken = i_flags.cf;
      COND_NC:  o_taken = !i_flags.cf;
      COND_N:   o_taken = i_flags.nf;
      COND_NN:  o_taken = !i_flags.nf;
      COND_O:   o_taken = i_flags.of;
      COND_NO:  o_taken = !i_flags.of;
      COND_D0:  o_taken = i_flags.d0;
      COND_ND0: o_taken = !i_flags.d0;
      COND_LT:  o_taken = w_lt;
      COND_GE:  o_taken = !w_lt;
      COND_LE:  o_taken = i_flags.zf | w_lt;
      COND_GT:  o_taken = !i_flags.cf & !i_flags.zf;
      default:  o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_cond_unit.sv
// Conditional-jump sequencer: evaluates the captured condition, fetches the target bytes
// on a taken branch, and strobes the next PC. BRANCH_RELATIVE_EN adds 8-bit relative jumps.
module branch_cond_unit
  import branch_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input logic               i_clk,
  input logic               i_rst_n,
  branch_cond_unit_if.slave bus
);

  state_t        r_state;
  logic [3:0]    r_cond;
  flags_t        r_flags;
  logic [AW-1:0] r_pc;
  logic [7:0]    r_lo;
  logic          r_mem_req;
  logic [AW-1:0] r_mem_addr;
  logic          r_pc_load;
  logic [AW-1:0] r_pc_next;
  logic          r_taken;
  logic          r_busy;
  logic          r_done;
  logic          w_taken;
  logic          w_rel;
  logic [AW-1:0] w_rel_target;

  cond_eval u_cond_eval (
    .i_cond  (r_cond),
    .i_flags (r_flags),
    .o_taken (w_taken)
  );

`ifdef BRANCH_RELATIVE_EN
  logic r_rel;
  assign w_rel = r_rel;
`else
  logic w_unused_rel;
  assign w_unused_rel = bus.i_rel;
  assign w_rel        = 1'b0;
`endif

  // Offset is relative to the byte after the operand; wraps modulo 2^AW.
  assign w_rel_target = r_pc + AW'(1) + {{(AW-8){bus.i_mem_rdata[7]}}, bus.i_mem_rdata};

  // NOTE: sequential state uses non-blocking assignments only, so every register sees
  // pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_cond     <= '0;
      r_flags    <= '0;
      r_pc       <= '0;
      r_lo       <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_pc_load  <= 1'b0;
      r_pc_next  <= '0;
      r_taken    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
`ifdef BRANCH_RELATIVE_EN
      r_rel      <= 1'b0;
`endif
    end else begin
      r_pc_load <= 1'b0;
      r_done    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            r_cond  <= bus.i_cond;
            r_flags <= bus.i_flags;
            r_pc    <= bus.i_pc;
`ifdef BRANCH_RELATIVE_EN
            r_rel   <= bus.i_rel;
`endif
            r_busy  <= 1'b1;
            r_state <= EVAL;
          end
        end
        EVAL: begin
          r_taken <= w_taken;
          if (w_taken) begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_pc;
            r_state    <= FETCH_LO;
          end else begin
            r_pc_next <= w_rel ? r_pc + AW'(1) : r_pc + AW'(2);
            r_pc_load <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= SKIP;
          end
        end
        FETCH_LO: begin
          if (bus.i_mem_ack) begin
            r_lo <= bus.i_mem_rdata;
            if (w_rel) begin
              r_mem_req <= 1'b0;
              r_pc_next <= w_rel_target;
              r_pc_load <= 1'b1;
              r_done    <= 1'b1;
              r_state   <= LOAD;
            end else begin
              r_mem_addr <= r_pc + AW'(1);
              r_state    <= FETCH_HI;
            end
          end
        end
        FETCH_HI: begin
          if (bus.i_mem_ack) begin
            r_mem_req <= 1'b0;
            r_pc_next <= {bus.i_mem_rdata, r_lo};
            r_pc_load <= 1'b1;
            r_done    <= 1'b1;
            r_state   <= LOAD;
          end
        end
        LOAD, SKIP: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.o_mem_req  = r_mem_req;
  assign bus.o_mem_addr = r_mem_addr;
  assign bus.o_pc_load  = r_pc_load;
  assign bus.o_pc_next  = r_pc_next;
  assign bus.o_taken    = r_taken;
  assign bus.o_busy     = r_busy;
  assign bus.o_done     = r_done;

endmodule
